bfloat16_divider: RTL

- Sequential bfloat16 divider; computes quotient = num1 / num2. It is the inverse operation to the datapath's combinational bfloat16 multiplier.
- Uses the same number conventions as the multiplier: flush-to-zero (FTZ) on subnormals, truncation with no rounding, canonical NaN 16'h7FC0.
- Mantissa quotient is produced by a restoring divider at 1 bit/cycle.
- Valid/ready handshake on input and on output; one operation in flight at a time.

---
 rtl/bfloat16_divider_if.sv | 25 ++
 rtl/bfloat16_divider.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bfloat16_divider_if.sv
// Handshake and data bundle for the sequential bfloat16 divider.
// The master side supplies operands and consumes results; the slave side is the divider.
interface bfloat16_divider_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] num1;
    logic [15:0] num2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        is_NaN;
    logic        is_infinity;
    logic        is_zero;
    logic        div_by_zero;

    modport master (
        output in_valid, num1, num2, out_ready,
        input  in_ready, out_valid, result, is_NaN, is_infinity, is_zero, div_by_zero
    );

    modport slave (
        input  in_valid, num1, num2, out_ready,
        output in_ready, out_valid, result, is_NaN, is_infinity, is_zero, div_by_zero
    );
endinterface

// File: rtl/bfloat16_divider.sv
// Sequential bfloat16 divider: FTZ, truncating, canonical NaN, one restoring
// quotient bit per cycle, valid/ready on both sides, one operation in flight.
module bfloat16_divider #(
    parameter logic [15:0] CANON_NAN = 16'h7FC0
) (
    input  logic               clk,
    input  logic               rst,
    bfloat16_divider_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [8:0]         r_rem;
    logic [7:0]         r_div;
    logic [8:0]         r_quo;
    logic [3:0]         r_cnt;
    logic               r_sign;
    logic signed [9:0]  r_exp_base;
    logic [15:0]        r_result;
    logic [3:0]         r_flags;

    logic [7:0]         w_e1;
    logic [7:0]         w_e2;
    logic [6:0]         w_f1;
    logic [6:0]         w_f2;
    logic               w_nan1;
    logic               w_nan2;
    logic               w_inf1;
    logic               w_inf2;
    logic               w_zero1;
    logic               w_zero2;
    logic               w_sign;
    logic               w_accept;
    logic               w_special;
    logic [15:0]        w_spec_result;
    logic [3:0]         w_spec_flags;
    logic               w_ge;
    logic [8:0]         w_rem_sub;
    logic signed [9:0]  w_exp_norm;
    logic [6:0]         w_frac_norm;
    logic [15:0]        w_norm_result;
    logic [3:0]         w_norm_flags;

    assign w_e1    = bus.num1[14:7];
    assign w_e2    = bus.num2[14:7];
    assign w_f1    = bus.num1[6:0];
    assign w_f2    = bus.num2[6:0];
    assign w_nan1  = (w_e1 == 8'hFF) && (w_f1 != 7'd0);
    assign w_nan2  = (w_e2 == 8'hFF) && (w_f2 != 7'd0);
    assign w_inf1  = (w_e1 == 8'hFF) && (w_f1 == 7'd0);
    assign w_inf2  = (w_e2 == 8'hFF) && (w_f2 == 7'd0);
    assign w_zero1 = (w_e1 == 8'h00);
    assign w_zero2 = (w_e2 == 8'h00);
    assign w_sign  = bus.num1[15] ^ bus.num2[15];
    assign w_accept = bus.in_valid && (r_state == S_IDLE);

    // Special-operand resolution; flags are ordered {nan, inf, zero, div_by_zero}.
    always_comb begin
        w_special     = 1'b1;
        w_spec_result = CANON_NAN;
        w_spec_flags  = 4'b1000;
        if (w_nan1 || w_nan2 || (w_zero1 && w_zero2) || (w_inf1 && w_inf2)) begin
            w_spec_result = CANON_NAN;
            w_spec_flags  = 4'b1000;
        end else if (w_inf1) begin
            w_spec_result = {w_sign, 8'hFF, 7'h00};
            w_spec_flags  = 4'b0100;
        end else if (w_zero2) begin
            w_spec_result = {w_sign, 8'hFF, 7'h00};
            w_spec_flags  = 4'b0101;
        end else if (w_zero1 || w_inf2) begin
            w_spec_result = {w_sign, 8'h00, 7'h00};
            w_spec_flags  = 4'b0010;
        end else begin
            w_special     = 1'b0;
            w_spec_result = 16'h0000;
            w_spec_flags  = 4'b0000;
        end
    end

    // One restoring step: subtract when the partial remainder covers the divisor.
    always_comb begin
        w_ge      = (r_rem >= {1'b0, r_div});
        w_rem_sub = r_rem;
        if (w_ge) begin
            w_rem_sub = r_rem - {1'b0, r_div};
        end else begin
            w_rem_sub = r_rem;
        end
    end

    // Normalisation of the 9-bit quotient plus exponent range handling.
    always_comb begin
        w_exp_norm    = r_exp_base + (r_quo[8] ? 10'sd1 : 10'sd0);
        w_frac_norm   = r_quo[8] ? r_quo[7:1] : r_quo[6:0];
        w_norm_result = 16'h0000;
        w_norm_flags  = 4'b0000;
        if (w_exp_norm > 10'sd254) begin
            w_norm_result = {r_sign, 8'hFF, 7'h00};
            w_norm_flags  = 4'b0100;
        end else if (w_exp_norm < 10'sd1) begin
            w_norm_result = {r_sign, 8'h00, 7'h00};
            w_norm_flags  = 4'b0010;
        end else begin
            w_norm_result = {r_sign, w_exp_norm[7:0], w_frac_norm};
            w_norm_flags  = 4'b0000;
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a result handed off in DONE never overlaps a new accept.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_special ? S_DONE : S_DIV;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_DIV: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_NORM;
                end else begin
                    w_state_next = S_DIV;
                end
            end
            S_NORM: w_state_next = S_DONE;
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iterative division and result registration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem      <= 9'd0;
            r_div      <= 8'd0;
            r_quo      <= 9'd0;
            r_cnt      <= 4'd0;
            r_sign     <= 1'b0;
            r_exp_base <= 10'sd0;
            r_result   <= 16'h0000;
            r_flags    <= 4'b0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign     <= w_sign;
                        r_rem      <= {2'b01, w_f1};
                        r_div      <= {1'b1, w_f2};
                        r_quo      <= 9'd0;
                        r_cnt      <= 4'd8;
                        r_exp_base <= $signed({2'b00, w_e1}) - $signed({2'b00, w_e2}) + 10'sd126;
                        if (w_special) begin
                            r_result <= w_spec_result;
                            r_flags  <= w_spec_flags;
                        end
                    end
                end
                S_DIV: begin
                    // Quotient bits arrive MSB first, so shifting in equals setting Q[cnt].
                    r_rem <= {w_rem_sub[7:0], 1'b0};
                    r_quo <= {r_quo[7:0], w_ge};
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_NORM: begin
                    r_result <= w_norm_result;
                    r_flags  <= w_norm_flags;
                end
                S_DONE: begin
                    r_result <= r_result;
                end
                default: begin
                    r_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign bus.in_ready    = (r_state == S_IDLE);
    assign bus.out_valid   = (r_state == S_DONE);
    assign bus.result      = r_result;
    assign bus.is_NaN      = r_flags[3];
    assign bus.is_infinity = r_flags[2];
    assign bus.is_zero     = r_flags[1];
    assign bus.div_by_zero = r_flags[0];

endmodule
